mem_port_arbiter: RTL
=====================

# mem_port_arbiter

Two-requester arbiter for the single 256-bit Data Memory port. The instruction cache (port 0) and data cache (port 1) each issue line-sized read or write transactions with the same enable/ack handshake the data cache uses toward memory. The arbiter grants one requester at a time, round-robin, and holds a registered copy of that request on the memory bus until `mem_ack_i`. It steers the ack and read data back combinationally and flags transactions that exceed a cycle budget.

## Interface
- `TIMEOUT`, default 255: memory-busy cycles before `err_o` sets; range 1..1023.
- `clk_i`  in  1  system clock, rising edge.
- `rst_i`  in  1  asynchronous, active-low reset.
- `p0_enable_i`  in  1  port 0 request; held high until acked.
- `p0_write_i`  in  1  port 0: 1 = write line, 0 = read line.
- `p0_addr_i`  in  32  port 0 line address (bits [4:0] ignored, forced 0 on the bus).
- `p0_data_i`  in  256  port 0 write data.
- `p0_data_o`  out  256  port 0 read data, valid while `p0_ack_o`.
- `p0_ack_o`  out  1  port 0 completion, one-cycle pulse.
- `p1_*`: same six signals for port 1.
- `mem_data_i`  in  256  memory read data, valid with `mem_ack_i`.
- `mem_ack_i`  in  1  memory completion.
- `mem_enable_o`  out  1  memory request.
- `mem_write_o`  out  1  memory write strobe.
- `mem_addr_o`  out  32  memory address, `[4:0]` always 0.
- `mem_data_o`  out  256  memory write data.
- `grant_o`  out  1  port currently or last granted.
- `busy_o`  out  1  a transaction is outstanding.
- `err_o`  out  1  sticky timeout flag.

## Operation
- **States**
  - IDLE: no transaction; requests are sampled.
  - BUSY: one transaction outstanding on the memory bus.
  - DONE: one-cycle turnaround after an ack.
- **IDLE**
  - If any `pN_enable_i` is high at a rising edge, go to BUSY.
  - Set `grant` to the winner.
  - Capture the winner's write, addr[31:5] and data into the command registers.
  - Clear the busy counter.
- **Arbitration: round-robin on `last`**
  - `last` is the most recently granted port; it resets to 1.
  - Both ports requesting: grant `~last`.
  - One port requesting: grant that port.
  - `last` updates at grant.
- **BUSY**
  - `mem_enable_o`=1; `mem_write_o`, `mem_addr_o` (`{addr[31:5],5'b0}`) and `mem_data_o` are driven from the command registers.
  - These values stay stable for the whole of BUSY, even if the requester changes its inputs.
  - When `mem_ack_i`=1, go to DONE.
- **Ack routing (combinational)**
  - `pN_ack_o = mem_ack_i & busy_o & (grant==N)`.
  - `pN_data_o = mem_data_i` while `pN_ack_o`, else 0.
  - `mem_ack_i` outside BUSY is ignored: no port ack and no state change.
- **DONE**
  - `mem_enable_o`=0 and all requests are ignored.
  - Always go to IDLE next cycle.
  - This covers a requester that drops `enable` one cycle after seeing ack.
- **Back-to-back transactions**
  - A requester that keeps `enable` high across two transactions (for example writeback then refill) must present the new command by the IDLE cycle after DONE.
  - That command is captured at the IDLE grant edge.
- **Busy counter**
  - 10 bits; increments every BUSY cycle and saturates at 1023.
  - When it reaches `TIMEOUT` with no ack, `err_o` sets.
  - `err_o` clears only on reset; the transaction is not aborted.
- **Reset**
  - Any time, including mid-BUSY: state IDLE, `last`=1, `grant`=0, command registers 0, counter 0.
  - All outputs 0.
  - A memory ack arriving after reset is ignored.

## Timing
- Grant latency: request high in cycle k (IDLE) gives `mem_enable_o` high from cycle k+1.
- Ack path: zero-cycle combinational; memory ack in cycle m gives `pN_ack_o` in cycle m.
- Turnaround: DONE in m+1, IDLE in m+2, next grant visible at m+3.
- Minimum occupancy per transaction: 3 cycles plus memory latency.
- `grant_o` changes only at an IDLE→BUSY edge; `busy_o` = (state==BUSY).
- `err_o` rises on the edge where the counter becomes `TIMEOUT`, i.e. after `TIMEOUT` BUSY cycles without ack.

## Test plan
- **Single read, port 1:** `p1_enable_i`=1, write=0, addr=0x0000_1234; memory acks 10 cycles after enable with data=256'hA5…
  - `mem_addr_o`=0x0000_1220, `mem_write_o`=0.
  - `p1_ack_o` pulses with data A5…; `p0_ack_o` stays 0.
- **Simultaneous requests after reset:** both ports request reads.
  - Port 0 is served first (`grant_o`=0), then port 1 at m+3.
  - With both still requesting afterwards, grants alternate 0,1,0,1.
- **Command stability:** port 0 write, addr 0x40, data D; change `p0_addr_i` and `p0_data_i` mid-BUSY.
  - `mem_addr_o`=0x40, `mem_data_o`=D and `mem_write_o`=1 hold until ack.
- **Back-to-back, one port:** port 1 keeps enable high through a write to 0x400, then switches to a read of 0x800 in the DONE cycle.
  - Second grant captures the read of 0x800; no duplicate write is issued.
- **Timeout:** `TIMEOUT`=4, memory never acks.
  - `err_o` rises after the 4th BUSY cycle and remains high.
  - A later ack still completes normally.
- **Reset mid-BUSY:** assert `rst_i`=0 during BUSY, then a stray `mem_ack_i`.
  - Outputs go to 0 immediately; no port ack occurs.
  - The next request is granted normally.

Source files
------------

// File: rtl/mem_port_arbiter_if.sv
// Signal bundle between the two cache requesters, the Data Memory port and the arbiter.
// The slave modport is the arbiter's view; master is the view of everything around it.
interface mem_port_arbiter_if;
    logic         p0_enable_i;
    logic         p0_write_i;
    logic [31:0]  p0_addr_i;
    logic [255:0] p0_data_i;
    logic [255:0] p0_data_o;
    logic         p0_ack_o;

    logic         p1_enable_i;
    logic         p1_write_i;
    logic [31:0]  p1_addr_i;
    logic [255:0] p1_data_i;
    logic [255:0] p1_data_o;
    logic         p1_ack_o;

    logic [255:0] mem_data_i;
    logic         mem_ack_i;
    logic         mem_enable_o;
    logic         mem_write_o;
    logic [31:0]  mem_addr_o;
    logic [255:0] mem_data_o;

    logic         grant_o;
    logic         busy_o;
    logic         err_o;

    modport slave (
        input  p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        output p0_data_o, p0_ack_o,
        input  p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        output p1_data_o, p1_ack_o,
        input  mem_data_i, mem_ack_i,
        output mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        output grant_o, busy_o, err_o
    );

    modport master (
        output p0_enable_i, p0_write_i, p0_addr_i, p0_data_i,
        input  p0_data_o, p0_ack_o,
        output p1_enable_i, p1_write_i, p1_addr_i, p1_data_i,
        input  p1_data_o, p1_ack_o,
        output mem_data_i, mem_ack_i,
        input  mem_enable_o, mem_write_o, mem_addr_o, mem_data_o,
        input  grant_o, busy_o, err_o
    );
endinterface

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one 256-bit Data Memory port between I-cache (0) and D-cache (1).
// The winning command is registered at grant and held on the bus until the memory acks.
module mem_port_arbiter #(
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    mem_port_arbiter_if.slave    bus
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam logic [9:0] TO_LIMIT = TIMEOUT[9:0];

    state_t        r_state;
    state_t        w_state_nxt;
    logic          r_last;
    logic          r_grant;
    logic          r_cmd_write;
    logic [26:0]   r_cmd_addr;
    logic [255:0]  r_cmd_data;
    logic [9:0]    r_cnt;
    logic          r_err;

    logic          w_req;
    logic          w_win;
    logic          w_busy;
    logic          w_sel_write;
    logic [26:0]   w_sel_addr;
    logic [255:0]  w_sel_data;
    logic [9:0]    w_cnt_inc;
    logic          w_unused;

    assign w_req  = bus.p0_enable_i | bus.p1_enable_i;
    // Contention goes to whoever did not win last; a lone requester always wins.
    assign w_win  = (bus.p0_enable_i & bus.p1_enable_i) ? ~r_last : bus.p1_enable_i;
    assign w_busy = (r_state == BUSY);

    assign w_sel_write = w_win ? bus.p1_write_i      : bus.p0_write_i;
    assign w_sel_addr  = w_win ? bus.p1_addr_i[31:5] : bus.p0_addr_i[31:5];
    assign w_sel_data  = w_win ? bus.p1_data_i       : bus.p0_data_i;
    assign w_cnt_inc   = (r_cnt == 10'h3FF) ? r_cnt : r_cnt + 10'd1;

    // Line offset bits never reach the memory bus.
    assign w_unused = ^{bus.p0_addr_i[4:0], bus.p1_addr_i[4:0]};

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (w_req) w_state_nxt = BUSY;
            BUSY:    if (bus.mem_ack_i) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state     <= IDLE;
            r_last      <= 1'b1;
            r_grant     <= 1'b0;
            r_cmd_write <= 1'b0;
            r_cmd_addr  <= '0;
            r_cmd_data  <= '0;
            r_cnt       <= '0;
            r_err       <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            if (r_state == IDLE && w_req) begin
                r_grant     <= w_win;
                r_last      <= w_win;
                r_cmd_write <= w_sel_write;
                r_cmd_addr  <= w_sel_addr;
                r_cmd_data  <= w_sel_data;
                r_cnt       <= '0;
            end
            if (w_busy) begin
                r_cnt <= w_cnt_inc;
                // Flag only; the stuck transaction stays on the bus.
                if (!bus.mem_ack_i && w_cnt_inc == TO_LIMIT) r_err <= 1'b1;
            end
        end
    end

    assign bus.mem_enable_o = w_busy;
    assign bus.mem_write_o  = w_busy & r_cmd_write;
    assign bus.mem_addr_o   = w_busy ? {r_cmd_addr, 5'b0} : 32'd0;
    assign bus.mem_data_o   = w_busy ? r_cmd_data : 256'd0;

    assign bus.p0_ack_o  = bus.mem_ack_i & w_busy & ~r_grant;
    assign bus.p1_ack_o  = bus.mem_ack_i & w_busy &  r_grant;
    assign bus.p0_data_o = bus.p0_ack_o ? bus.mem_data_i : 256'd0;
    assign bus.p1_data_o = bus.p1_ack_o ? bus.mem_data_i : 256'd0;

    assign bus.grant_o = r_grant;
    assign bus.busy_o  = w_busy;
    assign bus.err_o   = r_err;
endmodule
